// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the Execute-stage front end:
//   state_t          sequencer FSM states (RUN / MEM / FLUSH)
//   UOP_*            5-bit uop encoding presented by Decode
//   uop_writes_reg   1 if the uop writes the register file
//   uop_sets_flags   1 if the uop updates the flags register
// Codes 0..9 are ALU uops, 10..12 are memory/branch, 13..31 are unassigned and
// execute as no-ops.
// -----------------------------------------------------------------------------
package exec_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MEM   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] UOP_ADD    = 5'd0;
  localparam logic [4:0] UOP_SUB    = 5'd1;
  localparam logic [4:0] UOP_AND    = 5'd2;
  localparam logic [4:0] UOP_OR     = 5'd3;
  localparam logic [4:0] UOP_XOR    = 5'd4;
  localparam logic [4:0] UOP_NOT    = 5'd5;
  localparam logic [4:0] UOP_MOV    = 5'd6;  // register only, flags untouched
  localparam logic [4:0] UOP_CMP    = 5'd7;  // flags only
  localparam logic [4:0] UOP_TST    = 5'd8;  // flags only
  localparam logic [4:0] UOP_NOP    = 5'd9;
  localparam logic [4:0] UOP_LOAD   = 5'd10;
  localparam logic [4:0] UOP_STORE  = 5'd11;
  localparam logic [4:0] UOP_BRANCH = 5'd12;

  function automatic logic uop_writes_reg(input logic [4:0] uop);
    case (uop)
      UOP_ADD, UOP_SUB, UOP_AND, UOP_OR, UOP_XOR, UOP_NOT, UOP_MOV: return 1'b1;
      default:                                                       return 1'b0;
    endcase
  endfunction

  function automatic logic uop_sets_flags(input logic [4:0] uop);
    case (uop)
      UOP_ADD, UOP_SUB, UOP_AND, UOP_OR, UOP_XOR, UOP_NOT,
      UOP_CMP, UOP_TST:                                              return 1'b1;
      default:                                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
// Control FSM in front of the Execute stage. Accepts one uop per cycle from
// Decode and produces the register/flags write enables, the in_reg mux select
// and the dcache request. Stalls Decode while a load/store is outstanding and
// squashes FLUSH_CYCLES younger uops after a taken branch.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   dec_valid, dec_uop    uop offered by Decode
//   dec_ready             sequencer accepts the uop this cycle (state != MEM)
//   bcc_ok                branch condition, valid alongside a branch uop
//   mem_ack               dcache access complete
//   ex_fire               uop executes this cycle
//   reg_we, flags_we      register file / flags write enables
//   in_mux_sel            1 = dcache_out into in_reg, 0 = alu_out
//   mem_req, mem_we       dcache request and direction (1 = store)
//   pc_load               one-cycle pulse applying the branch delta
//   flush                 the Decode uop of this cycle is squashed
//   mem_err               sticky memory-timeout flag, cleared only by reset
//   retired_cnt           executed-uop count, wraps at 16 bits
//
// All pulse outputs are decoded combinationally from state and inputs and are
// forced low while rst_n is low.
// -----------------------------------------------------------------------------
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,   // 1..15
  parameter int unsigned MEM_TIMEOUT  = 16   // 2..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [4:0]  dec_uop,
  output logic        dec_ready,
  input  logic        bcc_ok,
  input  logic        mem_ack,
  output logic        ex_fire,
  output logic        reg_we,
  output logic        flags_we,
  output logic        in_mux_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_load,
  output logic        flush,
  output logic        mem_err,
  output logic [15:0] retired_cnt
);

  state_t      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  tmo_cnt_inc;
  logic [4:0]  lat_uop_q, lat_uop_d;
  logic        mem_err_q, mem_err_d;
  logic [15:0] retired_q;

  assign tmo_cnt_inc = tmo_cnt_q + 8'd1;
  assign dec_ready   = (state_q != ST_MEM);
  assign mem_err     = mem_err_q;
  assign retired_cnt = retired_q;

  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    lat_uop_d   = lat_uop_q;
    mem_err_d   = mem_err_q;
    ex_fire     = 1'b0;
    reg_we      = 1'b0;
    flags_we    = 1'b0;
    in_mux_sel  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_load     = 1'b0;
    flush       = 1'b0;

    // Reset is asynchronous, so pulses must vanish the moment rst_n falls,
    // not at the next edge.
    if (rst_n) begin
      case (state_q)
        ST_RUN: begin
          if (dec_valid) begin
            ex_fire = 1'b1;
            if (dec_uop == UOP_LOAD || dec_uop == UOP_STORE) begin
              mem_req   = 1'b1;
              mem_we    = (dec_uop == UOP_STORE);
              lat_uop_d = dec_uop;
              tmo_cnt_d = 8'd0;
              state_d   = ST_MEM;
            end else if (dec_uop == UOP_BRANCH) begin
              if (bcc_ok) begin
                pc_load     = 1'b1;
                flush_cnt_d = 4'(FLUSH_CYCLES);
                state_d     = ST_FLUSH;
              end
            end else begin
              reg_we   = uop_writes_reg(dec_uop);
              flags_we = uop_sets_flags(dec_uop);
            end
          end
        end

        ST_MEM: begin
          mem_req   = 1'b1;
          mem_we    = (lat_uop_q == UOP_STORE);
          tmo_cnt_d = tmo_cnt_inc;
          // An ack in the abort cycle still completes normally.
          if (mem_ack) begin
            if (lat_uop_q == UOP_LOAD) begin
              reg_we     = 1'b1;
              in_mux_sel = 1'b1;
            end
            state_d = ST_RUN;
          end else if (tmo_cnt_inc == 8'(MEM_TIMEOUT - 1)) begin
            // Request cycle plus MEM_TIMEOUT-1 MEM cycles: mem_req is seen
            // high for exactly MEM_TIMEOUT cycles before it drops.
            mem_err_d = 1'b1;
            state_d   = ST_RUN;
          end
        end

        ST_FLUSH: begin
          // Only an offered uop consumes a squash slot; idle cycles do not.
          if (dec_valid) begin
            flush       = 1'b1;
            flush_cnt_d = flush_cnt_q - 4'd1;
            if (flush_cnt_q == 4'd1) state_d = ST_RUN;
          end
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 4'd0;
      tmo_cnt_q   <= 8'd0;
      lat_uop_q   <= 5'd0;
      mem_err_q   <= 1'b0;
      retired_q   <= 16'd0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      lat_uop_q   <= lat_uop_d;
      mem_err_q   <= mem_err_d;
      if (ex_fire) retired_q <= retired_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exec_sequencer
// Directed bench for exec_sequencer with default parameters
// (FLUSH_CYCLES = 2, MEM_TIMEOUT = 16). Inputs change on the falling edge and
// outputs are sampled 1 ns later, well clear of the rising edge.
// -----------------------------------------------------------------------------
module tb_exec_sequencer;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic [4:0]  dec_uop;
  logic        dec_ready;
  logic        bcc_ok;
  logic        mem_ack;
  logic        ex_fire;
  logic        reg_we;
  logic        flags_we;
  logic        in_mux_sel;
  logic        mem_req;
  logic        mem_we;
  logic        pc_load;
  logic        flush;
  logic        mem_err;
  logic [15:0] retired_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  exec_sequencer #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_valid   (dec_valid),
    .dec_uop     (dec_uop),
    .dec_ready   (dec_ready),
    .bcc_ok      (bcc_ok),
    .mem_ack     (mem_ack),
    .ex_fire     (ex_fire),
    .reg_we      (reg_we),
    .flags_we    (flags_we),
    .in_mux_sel  (in_mux_sel),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .pc_load     (pc_load),
    .flush       (flush),
    .mem_err     (mem_err),
    .retired_cnt (retired_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] u, input logic b, input logic a);
    dec_valid = v;
    dec_uop   = u;
    bcc_ok    = b;
    mem_ack   = a;
  endtask

  // Hold one valid ALU uop for n cycles, ending on a falling edge.
  task automatic run_alu(input int n);
    drive(1'b1, UOP_ADD, 1'b0, 1'b0);
    repeat (n) @(negedge clk);
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 16'(n);
  endtask

  int          req_hi;
  int          rdy_lo;
  logic        bad_we;
  logic        bad_fire;
  logic        saw_drop;

  initial begin
    rst_n = 1'b0;
    drive(1'b1, UOP_LOAD, 1'b0, 1'b0);   // pulses must stay low during reset
    exp_cnt = 16'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ex_fire",   32'(ex_fire),     32'd0);
    check("rst_mem_req",   32'(mem_req),     32'd0);
    check("rst_dec_ready", 32'(dec_ready),   32'd1);
    check("rst_retired",   32'(retired_cnt), 32'd0);
    check("rst_mem_err",   32'(mem_err),     32'd0);
    @(negedge clk);
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- ADD x3 ----
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, UOP_ADD, 1'b0, 1'b0);
      #1;
      check("add_ex_fire", 32'(ex_fire),  32'd1);
      check("add_reg_we",  32'(reg_we),   32'd1);
      check("add_flags",   32'(flags_we), 32'd1);
      @(negedge clk);
    end
    exp_cnt = 16'd3;
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    #1;
    check("idle_ex_fire",  32'(ex_fire),     32'd0);
    check("add_retired",   32'(retired_cnt), 32'd3);

    // ---- other ALU decodes ----
    @(negedge clk);
    drive(1'b1, UOP_MOV, 1'b0, 1'b0);
    #1;
    check("mov_reg_we", 32'(reg_we),   32'd1);
    check("mov_flags",  32'(flags_we), 32'd0);
    @(negedge clk);
    drive(1'b1, UOP_CMP, 1'b0, 1'b0);
    #1;
    check("cmp_reg_we", 32'(reg_we),   32'd0);
    check("cmp_flags",  32'(flags_we), 32'd1);
    @(negedge clk);
    drive(1'b1, 5'd20, 1'b0, 1'b0);
    #1;
    check("unk_ex_fire", 32'(ex_fire),            32'd1);
    check("unk_enables", {30'd0, reg_we, flags_we}, 32'd0);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd3;
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    #1;
    check("alu_retired", 32'(retired_cnt), 32'(exp_cnt));

    // ---- LOAD with ack 3 cycles after the request ----
    @(negedge clk);
    drive(1'b1, UOP_LOAD, 1'b0, 1'b0);
    #1;
    check("ld_req_fire",   32'(ex_fire),    32'd1);
    check("ld_req_reg_we", 32'(reg_we),     32'd0);
    check("ld_mem_we",     32'(mem_we),     32'd0);
    req_hi   = int'(mem_req);
    rdy_lo   = 0;
    bad_we   = 1'b0;
    bad_fire = 1'b0;
    exp_cnt  = exp_cnt + 16'd1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive(1'b1, UOP_ADD, 1'b0, (j == 2));   // younger ADD waits behind the load
      #1;
      req_hi += int'(mem_req);
      rdy_lo += int'(!dec_ready);
      if (ex_fire) bad_fire = 1'b1;
      if (j < 2 && (reg_we || in_mux_sel)) bad_we = 1'b1;
      if (j == 2) begin
        check("ld_ack_reg_we", 32'(reg_we),     32'd1);
        check("ld_ack_mux",    32'(in_mux_sel), 32'd1);
      end
    end
    check("ld_early_we",  32'(bad_we),   32'd0);
    check("ld_wait_fire", 32'(bad_fire), 32'd0);
    @(negedge clk);
    drive(1'b1, UOP_ADD, 1'b0, 1'b0);
    #1;
    req_hi += int'(mem_req);
    check("ld_req_cycles", 32'(req_hi),     32'd4);
    check("ld_rdy_low",    32'(rdy_lo),     32'd3);
    check("ld_next_fire",  32'(ex_fire),    32'd1);
    check("ld_next_mux",   32'(in_mux_sel), 32'd0);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    #1;
    check("ld_retired", 32'(retired_cnt), 32'(exp_cnt));

    // ---- taken branch, idle, two squashed uops, then execution ----
    @(negedge clk);
    drive(1'b1, UOP_BRANCH, 1'b1, 1'b0);
    #1;
    check("br_pc_load", 32'(pc_load), 32'd1);
    check("br_fire",    32'(ex_fire), 32'd1);
    check("br_flush",   32'(flush),   32'd0);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    #1;
    check("fl_idle_flush", 32'(flush),     32'd0);
    check("fl_idle_ready", 32'(dec_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, UOP_ADD, 1'b0, 1'b0);
    #1;
    check("fl1_flush",  32'(flush),                 32'd1);
    check("fl1_quiet",  {29'd0, ex_fire, reg_we, pc_load}, 32'd0);
    @(negedge clk);
    drive(1'b1, UOP_BRANCH, 1'b1, 1'b0);
    #1;
    check("fl2_flush",  32'(flush),                 32'd1);
    check("fl2_quiet",  {29'd0, ex_fire, pc_load, flags_we}, 32'd0);
    @(negedge clk);
    drive(1'b1, UOP_ADD, 1'b0, 1'b0);
    #1;
    check("fl3_flush",  32'(flush),   32'd0);
    check("fl3_fire",   32'(ex_fire), 32'd1);
    check("fl3_reg_we", 32'(reg_we),  32'd1);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    #1;
    check("br_retired", 32'(retired_cnt), 32'(exp_cnt));

    // ---- STORE with no ack: abort after MEM_TIMEOUT request cycles ----
    @(negedge clk);
    drive(1'b1, UOP_STORE, 1'b0, 1'b0);
    #1;
    check("st_mem_we", 32'(mem_we), 32'd1);
    req_hi   = int'(mem_req);
    bad_we   = 1'b0;
    saw_drop = 1'b0;
    exp_cnt  = exp_cnt + 16'd1;
    for (int k = 0; k < 40 && !saw_drop; k++) begin
      @(negedge clk);
      drive(1'b1, UOP_ADD, 1'b0, 1'b0);
      #1;
      if (mem_req) begin
        req_hi += 1;
        if (reg_we || ex_fire || !mem_we) bad_we = 1'b1;
      end else begin
        saw_drop = 1'b1;
      end
    end
    check("st_drop_seen", 32'(saw_drop), 32'd1);
    check("st_req_cycles", 32'(req_hi),  32'd16);
    check("st_no_write",   32'(bad_we),  32'd0);
    check("st_mem_err",    32'(mem_err), 32'd1);
    check("st_next_fire",  32'(ex_fire), 32'd1);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("st_err_sticky", 32'(mem_err),     32'd1);
    check("st_retired",    32'(retired_cnt), 32'(exp_cnt));

    // ---- reset clears mem_err; LOAD acked on the exact timeout cycle ----
    rst_n = 1'b0;
    #1;
    check("rst2_mem_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 16'd0;
    @(negedge clk);
    drive(1'b1, UOP_LOAD, 1'b0, 1'b0);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      drive(1'b0, UOP_NOP, 1'b0, (j == 14));
      #1;
      if (j == 14) begin
        check("tmo_ack_req",    32'(mem_req), 32'd1);
        check("tmo_ack_reg_we", 32'(reg_we),  32'd1);
      end
    end
    @(negedge clk);
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    #1;
    check("tmo_ack_err",   32'(mem_err),   32'd0);
    check("tmo_ack_drop",  32'(mem_req),   32'd0);
    check("tmo_ack_ready", 32'(dec_ready), 32'd1);

    // ---- reset asserted mid-MEM ----
    @(negedge clk);
    drive(1'b1, UOP_LOAD, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    #1;
    check("mid_mem_req", 32'(mem_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req",   32'(mem_req),   32'd0);
    check("mid_rst_ready", 32'(dec_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, UOP_ADD, 1'b0, 1'b0);
    #1;
    check("mid_rst_run", 32'(ex_fire), 32'd1);
    check("mid_rst_req2", 32'(mem_req), 32'd0);
    @(negedge clk);
    exp_cnt = 16'd1;
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    #1;
    check("mid_rst_cnt", 32'(retired_cnt), 32'd1);

    // ---- retired_cnt wrap ----
    @(negedge clk);
    run_alu(int'(16'hFFFF - exp_cnt));
    #1;
    check("cnt_ffff", 32'(retired_cnt), 32'h0000_FFFF);
    @(negedge clk);
    run_alu(1);
    #1;
    check("cnt_wrap", 32'(retired_cnt), 32'd0);

    // ---- untaken branch ----
    @(negedge clk);
    drive(1'b1, UOP_BRANCH, 1'b0, 1'b0);
    #1;
    check("nbr_pc_load", 32'(pc_load), 32'd0);
    check("nbr_fire",    32'(ex_fire), 32'd1);
    @(negedge clk);
    drive(1'b1, UOP_ADD, 1'b0, 1'b0);
    #1;
    check("nbr_flush", 32'(flush),   32'd0);
    check("nbr_next",  32'(ex_fire), 32'd1);
    @(negedge clk);
    drive(1'b0, UOP_NOP, 1'b0, 1'b0);
    #1;
    check("nbr_retired", 32'(retired_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
